// File: rtl/spi_pkg.sv
// Shared SPI definitions for the target and master peripherals.
// No logic of its own; types, frame constants and the TX reload rule.
// No flow control here; consumers apply their own strobes.
package spi_pkg;

    // Frame-level state of an SPI endpoint
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    localparam int BITS_PER_FRAME = 8;

    // Counter must hold 0..BITS_PER_FRAME: the value BITS_PER_FRAME marks
    // "last rise seen, waiting for the closing fall".
    localparam int BIT_CNT_W = $clog2(BITS_PER_FRAME + 1);
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    localparam bit_cnt_t LAST_BIT_CNT  = bit_cnt_t'(BITS_PER_FRAME - 1);
    localparam bit_cnt_t FRAME_END_CNT = bit_cnt_t'(BITS_PER_FRAME);

    localparam logic [7:0] SPI_IDLE_BYTE_DEFAULT = 8'hFF;

    // Byte that enters the TX shifter at frame start: the pending byte,
    // or the idle filler when the CPU has nothing queued.
    function automatic logic [7:0] spi_reload_byte(input logic       empty,
                                                   input logic [7:0] hold,
                                                   input logic [7:0] idle_byte);
        return empty ? idle_byte : hold;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Synchronizes one asynchronous pin into clock_in and flags its edges.
// Latency: SYNC_STAGES cycles to q_o; rise_o/fall_o valid in that same cycle.
// No backpressure; edges narrower than one clock_in period may be lost.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,     // 2 or 3
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clock_in,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    // Metastability chain plus one extra flop holding the previous synced value
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = chain_q[SYNC_STAGES-1];
    assign rise_o =  q_o & ~prev_q;
    assign fall_o = ~q_o &  prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, 8-bit MSB-first frames, CPU side via load/unload strobes.
// Latency: pin edge acted on SYNC_STAGES+1 cycles later; rx_valid 1 cycle after 8th rise.
// No backpressure: an unread RX byte is overwritten (overrun), a pending TX byte is replaced on load.
module spi_target
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEFAULT
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       load,
    input  logic       unload,
    input  logic [7:0] datain,
    output logic [7:0] dataout,
    output logic       rx_valid,
    output logic       tx_empty,
    output logic       overrun,
    output logic       busy,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ssn,
    output logic       miso,
    output logic       miso_oe
);

    // Synchronized pins and edge pulses
    logic sclk_s, sclk_rise, sclk_fall;
    logic ssn_s, ssn_rise, ssn_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_edges;

    // Frame state
    spi_state_e state_q;
    bit_cnt_t   cnt_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic       busy_q;
    logic       miso_oe_q;

    // CPU-side registers
    logic [7:0] hold_q;
    logic       tx_empty_q;
    logic [7:0] dataout_q;
    logic       rx_valid_q;
    logic       overrun_q;

    // Combinational helpers
    logic [7:0] reload_byte_d;
    logic [7:0] rx_byte_d;
    logic       reload_take_d;
    logic       frame_done_d;

    spi_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clock_in (clock_in),
        .reset    (reset),
        .d_i      (sclk),
        .q_o      (sclk_s),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall)
    );

    // ssn resets to "asserted" so that a select already low when reset
    // releases produces no falling edge; only a fresh high-to-low starts a frame.
    spi_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_ssn (
        .clock_in (clock_in),
        .reset    (reset),
        .d_i      (ssn),
        .q_o      (ssn_s),
        .rise_o   (ssn_rise),
        .fall_o   (ssn_fall)
    );

    // Same depth as sclk so mosi is sampled with matching delay
    spi_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_mosi (
        .clock_in (clock_in),
        .reset    (reset),
        .d_i      (mosi),
        .q_o      (mosi_s),
        .rise_o   (mosi_rise),
        .fall_o   (mosi_fall)
    );

    // Deselect is handled by level, and mosi edges carry no meaning
    assign unused_edges = ^{ssn_rise, mosi_rise, mosi_fall, sclk_s};

    // Next-frame byte, completed RX byte and the two event qualifiers
    always_comb begin
        reload_byte_d = spi_reload_byte(tx_empty_q, hold_q, IDLE_BYTE);
        rx_byte_d     = {rx_q, mosi_s};
        reload_take_d = 1'b0;
        frame_done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            reload_take_d = ssn_fall;
        end else if (!ssn_s) begin
            reload_take_d = sclk_fall && (cnt_q == FRAME_END_CNT);
            frame_done_d  = sclk_rise && (cnt_q == LAST_BIT_CNT);
        end
    end

    // Frame FSM: select tracking, bit counting and both shift registers
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ssn_fall) begin
                        state_q   <= ST_SHIFT;
                        cnt_q     <= '0;
                        rx_q      <= '0;
                        tx_q      <= reload_byte_d;
                        busy_q    <= 1'b1;
                        miso_oe_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (ssn_s) begin
                        // Deselect mid-frame drops any partial byte silently
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        rx_q      <= '0;
                        busy_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end else if (sclk_rise && (cnt_q != FRAME_END_CNT)) begin
                        rx_q  <= rx_byte_d[6:0];
                        cnt_q <= cnt_q + 1'b1;
                    end else if (sclk_fall) begin
                        if (cnt_q == FRAME_END_CNT) begin
                            // Closing fall of a frame: line up the next one
                            cnt_q <= '0;
                            tx_q  <= reload_byte_d;
                        end else if (cnt_q != '0) begin
                            tx_q <= {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // TX holding register; a load in the reload cycle lands after the reload
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            tx_empty_q <= 1'b1;
        end else begin
            if (reload_take_d) begin
                tx_empty_q <= 1'b1;
            end
            if (load) begin
                hold_q     <= datain;
                tx_empty_q <= 1'b0;
            end
        end
    end

    // RX data and flags; a completing byte beats a same-cycle unload
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            dataout_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (unload) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (frame_done_d) begin
                dataout_q  <= rx_byte_d;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !unload) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign dataout  = dataout_q;
    assign rx_valid = rx_valid_q;
    assign tx_empty = tx_empty_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;
    assign miso     = tx_q[7];
    assign miso_oe  = miso_oe_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: acts as SPI master and CPU, checks against a byte-level model.
// Inputs driven on clock_in falling edges, outputs sampled there too.
// Fixed cycle budgets throughout; no open-ended waits.
module tb_spi_target;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       load;
    logic       unload;
    logic [7:0] datain;
    logic [7:0] dataout;
    logic       rx_valid;
    logic       tx_empty;
    logic       overrun;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       ssn;
    logic       miso;
    logic       miso_oe;

    int total = 0;
    int bad   = 0;

    // Byte-level reference model of the CPU-visible state
    logic [7:0] m_hold;
    logic [7:0] m_dout;
    bit         m_empty;
    bit         m_rxv;
    bit         m_ovr;

    logic [7:0] exp_b;
    logic [7:0] got_b;
    logic [7:0] tx_b;
    bit         oe_seen;

    spi_target dut (
        .clock_in (clock_in),
        .reset    (reset),
        .load     (load),
        .unload   (unload),
        .datain   (datain),
        .dataout  (dataout),
        .rx_valid (rx_valid),
        .tx_empty (tx_empty),
        .overrun  (overrun),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .ssn      (ssn),
        .miso     (miso),
        .miso_oe  (miso_oe)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic m_reset();
        m_hold  = 8'h00;
        m_dout  = 8'h00;
        m_empty = 1'b1;
        m_rxv   = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Frame start: pending byte goes out, otherwise the idle filler
    task automatic m_start(output logic [7:0] b);
        b       = m_empty ? 8'hFF : m_hold;
        m_empty = 1'b1;
    endtask

    task automatic m_done(input logic [7:0] b, input bit same_unload);
        if (same_unload)
            m_ovr = 1'b0;
        else if (m_rxv)
            m_ovr = 1'b1;
        m_rxv  = 1'b1;
        m_dout = b;
    endtask

    task automatic cpu_load(input logic [7:0] v);
        load   = 1'b1;
        datain = v;
        cyc(1);
        load    = 1'b0;
        m_hold  = v;
        m_empty = 1'b0;
    endtask

    task automatic cpu_unload();
        unload = 1'b1;
        cyc(1);
        unload = 1'b0;
        m_rxv  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"}, dataout, m_dout);
        check({tag, ".rxv"}, 8'(rx_valid), 8'(m_rxv));
        check({tag, ".txe"}, 8'(tx_empty), 8'(m_empty));
        check({tag, ".ovr"}, 8'(overrun), 8'(m_ovr));
        check({tag, ".busy"}, 8'(busy), 8'h00);
        check({tag, ".oe"}, 8'(miso_oe), 8'h00);
    endtask

    // Master side: 4 clock_in low + 4 high per bit, miso sampled just before each rise
    task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                            input bit sel_start, input bit sel_end,
                            input bit mid_load, input logic [7:0] mid_val,
                            input bit unload_last,
                            output logic [7:0] rx, output bit oe_ok);
        rx    = 8'h00;
        oe_ok = 1'b1;
        if (sel_start) begin
            ssn = 1'b0;
            cyc(6);
        end
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            if (mid_load && i == 3) begin
                cpu_load(mid_val);
                cyc(3);
            end else begin
                cyc(4);
            end
            rx[7-i] = miso;
            if (!miso_oe || !busy) oe_ok = 1'b0;
            sclk = 1'b1;
            if (unload_last && i == nbits - 1) begin
                // Unload lands on the clock edge that completes the byte
                cyc(2);
                unload = 1'b1;
                cyc(1);
                unload = 1'b0;
                cyc(1);
            end else begin
                cyc(4);
            end
            sclk = 1'b0;
        end
        if (sel_end) begin
            cyc(4);
            ssn = 1'b1;
            cyc(6);
        end
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        unload = 1'b0;
        datain = 8'h00;
        sclk   = 1'b0;
        mosi   = 1'b0;
        ssn    = 1'b1;
        m_reset();
        cyc(3);
        reset = 1'b0;
        cyc(6);

        // Reset state
        check_all("rst");
        check("rst.miso", 8'(miso), 8'h00);

        // Single frame with a loaded TX byte
        cpu_load(8'hA5);
        m_start(exp_b);
        spi_xfer(8'h3C, 8, 1, 1, 0, 8'h00, 0, got_b, oe_seen);
        m_done(8'h3C, 0);
        check("single.miso", got_b, exp_b);
        check("single.oe_during", 8'(oe_seen), 8'h01);
        check_all("single");
        cpu_unload();

        // Nothing loaded: idle filler goes out
        m_start(exp_b);
        spi_xfer(8'h00, 8, 1, 1, 0, 8'h00, 0, got_b, oe_seen);
        m_done(8'h00, 0);
        check("empty.miso", got_b, exp_b);
        check_all("empty");
        cpu_unload();
        check_all("empty_unload");

        // Back-to-back frames, second byte loaded during the first frame
        cpu_load(8'h11);
        m_start(exp_b);
        spi_xfer(8'h01, 8, 1, 0, 1, 8'h22, 0, got_b, oe_seen);
        m_done(8'h01, 0);
        check("b2b1.miso", got_b, exp_b);
        m_start(exp_b);
        spi_xfer(8'h02, 8, 0, 1, 0, 8'h00, 0, got_b, oe_seen);
        m_done(8'h02, 0);
        check("b2b2.miso", got_b, exp_b);
        check("b2b2.oe_during", 8'(oe_seen), 8'h01);
        check_all("b2b");
        cpu_unload();
        check_all("b2b_unload");

        // Abort after 5 bits while a byte is still unread
        tx_b = 8'($urandom);
        cpu_load(8'($urandom));
        m_start(exp_b);
        spi_xfer(tx_b, 8, 1, 1, 0, 8'h00, 0, got_b, oe_seen);
        m_done(tx_b, 0);
        check("pre_abort.miso", got_b, exp_b);
        m_start(exp_b);
        spi_xfer(8'($urandom), 5, 1, 1, 0, 8'h00, 0, got_b, oe_seen);
        check_all("abort");
        tx_b = 8'($urandom);
        m_start(exp_b);
        spi_xfer(tx_b, 8, 1, 1, 0, 8'h00, 0, got_b, oe_seen);
        m_done(tx_b, 0);
        check("post_abort.miso", got_b, exp_b);
        check_all("post_abort");
        cpu_unload();

        // Unload in the completing cycle, with overrun already set beforehand
        for (int k = 0; k < 2; k++) begin
            tx_b = 8'($urandom);
            m_start(exp_b);
            spi_xfer(tx_b, 8, 1, 1, 0, 8'h00, 0, got_b, oe_seen);
            m_done(tx_b, 0);
        end
        check_all("pre_simul");
        tx_b = 8'($urandom);
        m_start(exp_b);
        spi_xfer(tx_b, 8, 1, 1, 0, 8'h00, 1, got_b, oe_seen);
        m_done(tx_b, 1);
        check_all("simul");
        cpu_unload();

        // Reset in the middle of a frame, with a byte pending
        cpu_load(8'h5A);
        m_start(exp_b);
        spi_xfer(8'($urandom), 3, 1, 0, 0, 8'h00, 0, got_b, oe_seen);
        cpu_load(8'hCD);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        m_reset();
        cyc(1);
        check_all("midrst");
        check("midrst.miso", 8'(miso), 8'h00);
        // Rest of the interrupted frame must be ignored
        spi_xfer(8'($urandom), 5, 0, 1, 0, 8'h00, 0, got_b, oe_seen);
        check_all("ignored");
        tx_b = 8'($urandom);
        m_start(exp_b);
        spi_xfer(tx_b, 8, 1, 1, 0, 8'h00, 0, got_b, oe_seen);
        m_done(tx_b, 0);
        check("after_rst.miso", got_b, exp_b);
        check_all("after_rst");
        cpu_unload();

        // Random traffic
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 1) cpu_load(8'($urandom));
            tx_b = 8'($urandom);
            m_start(exp_b);
            spi_xfer(tx_b, 8, 1, 1, 0, 8'h00, 0, got_b, oe_seen);
            m_done(tx_b, 0);
            check("rand.miso", got_b, exp_b);
            check("rand.oe_during", 8'(oe_seen), 8'h01);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) cpu_unload();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
